// File: rtl/lcd_spi_receiver_pkg.sv
// Shared widths and types for the LCD SPI receive path.
package lcd_spi_receiver_pkg;

  localparam int ENTRY_W       = 9;
  localparam int DC_BIT        = 8;
  localparam int BYTE_W        = 8;
  localparam int BITS_PER_BYTE = 8;
  localparam int BIT_CNT_W     = $clog2(BITS_PER_BYTE);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic dc, input logic [BYTE_W-1:0] b);
    logic [ENTRY_W-1:0] e;
    e = {ENTRY_W{1'b0}};
    e[DC_BIT] = dc;
    e[BYTE_W-1:0] = b;
    return e;
  endfunction

endpackage

// File: rtl/lcd_spi_rx_fifo.sv
// Synchronous show-ahead FIFO; head word reads as zero while empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module lcd_spi_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count     = CNT_W'(wr_ptr_q - rd_ptr_q);
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign rd_data   = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/lcd_spi_receiver.sv
// Oversampling SPI mode-0 receiver for the Hack TFT write stream, buffering {DC, byte}.
// Optional FRAME_ERR output is enabled by defining LCD_SPI_RX_FRAMEERR_EN.
module lcd_spi_receiver
  import lcd_spi_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic               CLK_100MHz,
  input  logic               RESET_N,
  input  logic               SPI_CS,
  input  logic               SPI_SCK,
  input  logic               SPI_SDI,
  input  logic               SPI_DC,
  input  logic               RD,
  input  logic               CLR_ERR,
  output logic [ENTRY_W-1:0] DATA,
  output logic               VALID,
  output logic [CNT_W-1:0]   COUNT,
`ifdef LCD_SPI_RX_FRAMEERR_EN
  output logic               FRAME_ERR,
`endif
  output logic               OVERFLOW
);

  // Synchronizer lanes: [3]=CS, [2]=SCK, [1]=SDI, [0]=DC
  logic [3:0]           sync1_q, sync2_q;
  logic                 sck_prev_q;
  logic                 cs_s, sck_s, sdi_s, dc_s, sck_rise_s;

  rx_state_e            state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-2:0]    sr_q, sr_d;
  logic                 push_q, push_d;
  logic [ENTRY_W-1:0]   push_data_q, push_data_d;
  logic                 ovf_q, ovf_d;
  logic                 fifo_full_s, fifo_empty_s, pop_s, ovf_set_s;

  assign cs_s       = sync2_q[3];
  assign sck_s      = sync2_q[2];
  assign sdi_s      = sync2_q[1];
  assign dc_s       = sync2_q[0];
  assign sck_rise_s = sck_s & ~sck_prev_q;

  // Pin synchronizers and SCK edge history
  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q    <= 4'b0000;
      sync2_q    <= 4'b0000;
      sck_prev_q <= 1'b0;
    end else begin
      sync1_q    <= {SPI_CS, SPI_SCK, SPI_SDI, SPI_DC};
      sync2_q    <= sync1_q;
      sck_prev_q <= sck_s;
    end
  end

  // Frame FSM: a CS rise always abandons any partial byte
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = {BIT_CNT_W{1'b0}};
        if (!cs_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cs_s) begin
          state_d   = ST_IDLE;
          bit_cnt_d = {BIT_CNT_W{1'b0}};
        end else if (sck_rise_s) begin
          sr_d      = {sr_q[BYTE_W-3:0], sdi_s};
          bit_cnt_d = bit_cnt_q + {{(BIT_CNT_W-1){1'b0}}, 1'b1};
          if (bit_cnt_q == BIT_CNT_W'(BITS_PER_BYTE - 1)) begin
            push_d      = 1'b1;
            push_data_d = make_entry(dc_s, {sr_q, sdi_s});
          end else begin
            push_d = 1'b0;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = {BIT_CNT_W{1'b0}};
      end
    endcase
  end

  assign pop_s     = RD & ~fifo_empty_s;
  assign ovf_set_s = push_q & fifo_full_s & ~pop_s;

  // Sticky overflow, set beats clear
  always_comb begin
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (CLR_ERR) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Receive state registers
  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= {BIT_CNT_W{1'b0}};
      sr_q        <= {(BYTE_W-1){1'b0}};
      push_q      <= 1'b0;
      push_data_q <= {ENTRY_W{1'b0}};
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef LCD_SPI_RX_FRAMEERR_EN
  logic frame_set_s;
  logic frame_err_q, frame_err_d;

  assign frame_set_s = (state_q == ST_SHIFT) & cs_s & (bit_cnt_q != {BIT_CNT_W{1'b0}});

  // Sticky framing error, set beats clear
  always_comb begin
    if (frame_set_s) begin
      frame_err_d = 1'b1;
    end else if (CLR_ERR) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // Framing error register
  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign FRAME_ERR = frame_err_q;
`endif

  lcd_spi_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (CLK_100MHz),
    .rst_n   (RESET_N),
    .push    (push_q),
    .wr_data (push_data_q),
    .pop     (RD),
    .rd_data (DATA),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (COUNT)
  );

  assign VALID    = ~fifo_empty_s;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_lcd_spi_receiver.sv
// Directed bench for lcd_spi_receiver: queue model checked every cycle plus literal spot checks.
module tb_lcd_spi_receiver;

  localparam int DEPTH = 8;

  typedef struct {
    int         due;
    logic [8:0] e;
  } pend_t;

  logic       clk, rst_n, cs, sck, sdi, dc, rd, clr_err;
  logic [8:0] data;
  logic       valid;
  logic [3:0] count;
  logic       ovf;
`ifdef LCD_SPI_RX_FRAMEERR_EN
  logic       ferr;
`endif

  lcd_spi_receiver #(.FIFO_DEPTH(DEPTH), .CNT_W(4)) dut (
    .CLK_100MHz (clk),
    .RESET_N    (rst_n),
    .SPI_CS     (cs),
    .SPI_SCK    (sck),
    .SPI_SDI    (sdi),
    .SPI_DC     (dc),
    .RD         (rd),
    .CLR_ERR    (clr_err),
    .DATA       (data),
    .VALID      (valid),
    .COUNT      (count),
`ifdef LCD_SPI_RX_FRAMEERR_EN
    .FRAME_ERR  (ferr),
`endif
    .OVERFLOW   (ovf)
  );

  int         total, bad, cyc, frame_bits;
  logic [7:0] drv_sr;
  logic [8:0] mq[$];
  pend_t      pend[$];
  int         fpend[$];
  logic       ovf_m, ferr_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: entries appear 4 edges after the 8th SCK rise is first sampled
  task automatic model_run();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        pend.delete();
        fpend.delete();
        ovf_m  = 1'b0;
        ferr_m = 1'b0;
      end else begin
        bit full_before, popped, set_o, set_f;
        pend_t p;
        cyc++;
        full_before = (mq.size() == DEPTH);
        popped = 1'b0;
        set_o = 1'b0;
        set_f = 1'b0;
        if (rd && mq.size() > 0) begin
          void'(mq.pop_front());
          popped = 1'b1;
        end
        while (pend.size() > 0 && pend[0].due == cyc) begin
          p = pend.pop_front();
          if (!full_before || popped) mq.push_back(p.e);
          else set_o = 1'b1;
        end
        while (fpend.size() > 0 && fpend[0] == cyc) begin
          void'(fpend.pop_front());
          set_f = 1'b1;
        end
        if (set_o) ovf_m = 1'b1;
        else if (clr_err) ovf_m = 1'b0;
        if (set_f) ferr_m = 1'b1;
        else if (clr_err) ferr_m = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    forever begin
      logic [8:0] exp_d;
      @(negedge clk);
      exp_d = (mq.size() > 0) ? mq[0] : 9'h000;
      chk("valid", 32'(valid), 32'(mq.size() > 0));
      chk("count", 32'(count), 32'(mq.size()));
      chk("data", 32'(data), 32'(exp_d));
      chk("overflow", 32'(ovf), 32'(ovf_m));
`ifdef LCD_SPI_RX_FRAMEERR_EN
      chk("frame_err", 32'(ferr), 32'(ferr_m));
`endif
    end
  endtask

  task automatic cs_begin();
    @(negedge clk);
    cs = 1'b0;
    sck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    @(negedge clk);
    sck = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b1;
    if (frame_bits % 8 != 0) fpend.push_back(cyc + 3);
    frame_bits = 0;
    repeat (4) @(negedge clk);
  endtask

  // mode 1: latency probe on last bit; mode 2: RD pulse landing on the push edge
  task automatic spi_bits(input logic [7:0] val, input int nbits, input logic dcv, input int mode);
    for (int i = 0; i < nbits; i++) begin
      logic  b;
      pend_t p;
      b = val[7-i];
      @(negedge clk);
      sck = 1'b0;
      sdi = b;
      dc = dcv;
      repeat (4) @(negedge clk);
      sck = 1'b1;
      drv_sr = {drv_sr[6:0], b};
      frame_bits++;
      if (frame_bits % 8 == 0) begin
        p.due = cyc + 4;
        p.e = {dcv, drv_sr};
        pend.push_back(p);
      end
      if (mode == 1 && i == nbits - 1) begin
        repeat (3) @(posedge clk);
        #1 chk("lat_valid_e3", 32'(valid), 32'd0);
        @(posedge clk);
        #1 chk("lat_valid_e4", 32'(valid), 32'd1);
      end else if (mode == 2 && i == nbits - 1) begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end else begin
        repeat (3) @(negedge clk);
      end
    end
  endtask

  task automatic pop();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    logic [8:0] e;
    rst_n = 1'b0; cs = 1'b1; sck = 1'b0; sdi = 1'b0; dc = 1'b0; rd = 1'b0; clr_err = 1'b0;
    total = 0; bad = 0; cyc = 0; frame_bits = 0; drv_sr = 8'h00;
    ovf_m = 1'b0; ferr_m = 1'b0;
    fork
      model_run();
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single command byte, latency, pop
    cs_begin();
    spi_bits(8'h2A, 8, 1'b0, 1);
    cs_end();
    chk("t1_data", 32'(data), 32'h02A);
    chk("t1_count", 32'(count), 32'd1);
    pop();
    chk("t1_valid_after_rd", 32'(valid), 32'd0);
    pop();
    chk("t1_rd_empty_count", 32'(count), 32'd0);

    // Back-to-back data bytes in one frame
    cs_begin();
    spi_bits(8'hA5, 8, 1'b1, 0);
    spi_bits(8'h3C, 8, 1'b1, 0);
    cs_end();
    chk("t2_count", 32'(count), 32'd2);
    chk("t2_data0", 32'(data), 32'h1A5);
    pop();
    chk("t2_data1", 32'(data), 32'h13C);
    pop();

    // Nine bytes into eight slots
    cs_begin();
    for (int i = 0; i < 9; i++) spi_bits(8'(8'h10 + i), 8, 1'(i % 2), 0);
    cs_end();
    chk("t3_count", 32'(count), 32'd8);
    chk("t3_ovf", 32'(ovf), 32'd1);
    clear_err();
    chk("t3_ovf_clr", 32'(ovf), 32'd0);
    for (int i = 0; i < 8; i++) begin
      e = {1'(i % 2), 8'(8'h10 + i)};
      chk("t3_entry", 32'(data), 32'(e));
      pop();
    end
    chk("t3_drained", 32'(valid), 32'd0);

    // Full FIFO with RD on the push edge
    cs_begin();
    for (int i = 0; i < 8; i++) spi_bits(8'(8'h20 + i), 8, 1'b0, 0);
    spi_bits(8'h99, 8, 1'b0, 2);
    cs_end();
    chk("t4_count", 32'(count), 32'd8);
    chk("t4_ovf", 32'(ovf), 32'd0);
    chk("t4_head", 32'(data), 32'h021);
    for (int i = 0; i < 7; i++) pop();
    chk("t4_tail", 32'(data), 32'h099);
    pop();

    // Aborted partial byte, then a full one
    cs_begin();
    spi_bits(8'hF0, 5, 1'b0, 0);
    cs_end();
    cs_begin();
    spi_bits(8'h55, 8, 1'b0, 0);
    cs_end();
    chk("t5_count", 32'(count), 32'd1);
    chk("t5_data", 32'(data), 32'h055);
`ifdef LCD_SPI_RX_FRAMEERR_EN
    chk("t5_frame_err", 32'(ferr), 32'd1);
    clear_err();
    chk("t5_frame_err_clr", 32'(ferr), 32'd0);
`endif
    pop();

    // Reset with three queued entries and a byte in flight
    cs_begin();
    spi_bits(8'h11, 8, 1'b0, 0);
    spi_bits(8'h22, 8, 1'b1, 0);
    spi_bits(8'h33, 8, 1'b0, 0);
    cs_end();
    chk("t6_pre_count", 32'(count), 32'd3);
    cs_begin();
    spi_bits(8'hC3, 4, 1'b0, 0);
    @(negedge clk);
    #3 rst_n = 1'b0;
    cs = 1'b1;
    sck = 1'b0;
    frame_bits = 0;
    #1 chk("t6_rst_valid", 32'(valid), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_data", 32'(data), 32'd0);
    chk("t6_rst_ovf", 32'(ovf), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    cs_begin();
    spi_bits(8'h81, 8, 1'b0, 0);
    cs_end();
    chk("t6_count", 32'(count), 32'd1);
    chk("t6_data", 32'(data), 32'h081);
    pop();

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_spi_receiver.md
# lcd_spi_receiver

SPI responder that decodes the 4-wire TFT write stream (CS, SCK, SDI, DC) the Hack computer drives to its LCD, turning it back into command/data bytes. Runs on the 100 MHz system clock, oversamples the SPI pins, and buffers each received byte with its DC flag in a small FIFO read through a strobe interface. Used as the display-side model in loopback builds and as the receive end when a second board mirrors the Hack display traffic.

## Interface
Parameters:
- FIFO_DEPTH, 8, number of buffered entries; power of two, 2..64
- CNT_W, 4, width of COUNT; must equal log2(FIFO_DEPTH)+1

Ports:
- CLK_100MHz  input  1  system clock; the only clock
- RESET_N  input  1  asynchronous, active-low reset
- SPI_CS  input  1  chip select, active low, asynchronous to CLK_100MHz
- SPI_SCK  input  1  SPI clock, mode 0, idle low, max 12.5 MHz
- SPI_SDI  input  1  serial data, MSB first
- SPI_DC  input  1  0 = command byte, 1 = data byte
- RD  input  1  pop strobe, one pop per cycle high
- CLR_ERR  input  1  clears sticky error flags
- DATA  output  9  FIFO head: [8] = DC, [7:0] = byte
- VALID  output  1  FIFO non-empty; DATA is meaningful
- COUNT  output  CNT_W  entries currently held
- OVERFLOW  output  1  sticky: a completed byte was dropped because FIFO was full

## Operation
- Input capture: SPI_CS, SPI_SCK, SPI_SDI, SPI_DC each pass a 2-FF synchronizer; SCK rising edge = synchronized SCK high and its previous-cycle copy low.
- States: IDLE (CS high) and SHIFT (CS low). IDLE: bit counter = 0, shift register held. CS falling -> SHIFT.
- SHIFT, per SCK rising edge: shift register <= {sr[6:0], SDI}; bit counter +1 (3-bit, wraps 7->0).
- On the 8th rising edge: byte = {sr[6:0], SDI}, DC = synchronized SPI_DC at that edge; entry pushed next cycle; counter wraps to 0, so back-to-back bytes within one CS assertion need no gap.
- CS rising mid-byte (counter != 0): partial byte discarded, counter cleared, -> IDLE. CS rising with counter = 0: -> IDLE, nothing lost.
- FIFO: show-ahead; DATA always reflects head. RD with VALID pops; RD while empty ignored, no state change.
- Push while full: entry dropped, OVERFLOW set. Push and pop in the same cycle while full: both occur, COUNT unchanged, no overflow.
- CLR_ERR clears OVERFLOW; if a set event occurs in the same cycle, set wins.
- Reset (any time, including mid-byte): state IDLE, counter 0, FIFO empty, DATA = 0, VALID = 0, COUNT = 0, OVERFLOW = 0, synchronizers 0.

## Timing
- SPI pin edge to internal edge detect: 3 CLK cycles (2 sync + 1 compare).
- 8th SCK rising edge at pin to VALID high (FIFO previously empty): exactly 4 CLK rising edges after the edge is first sampled.
- RD high at edge N: DATA/COUNT/VALID updated after edge N.
- SCK high and low phases must each be ≥ 4 CLK periods; faster SCK is out of spec, behaviour undefined.
- SDI and DC must be stable from the SCK rising edge until ≥ 3 CLK periods after it.

## Configuration
- LCD_SPI_RX_FRAMEERR_EN defined: adds output FRAME_ERR (1 bit, reset 0), sticky, set when CS rises with bit counter != 0; cleared by CLR_ERR with set-wins priority.
- Undefined: no FRAME_ERR port; partial bytes silently discarded.

## Structure
- Shared header/package: entry width (9), DC bit index (8), byte width (8), bits-per-byte (8).
- One sub-module: lcd_spi_rx_fifo, synchronous show-ahead FIFO (DEPTH, WIDTH) with push/pop/full/empty/count; pointers one bit wider than address for full/empty.

## Test plan
- Reset, CS low, send 0x2A with DC=0 at SCK = CLK/8 -> VALID after 4 cycles, DATA = 0x02A, COUNT = 1; RD -> VALID = 0.
- One CS frame with 0xA5,0x3C (DC=1) back-to-back -> DATA = 0x1A5 then 0x13C, no bytes lost.
- Push 9 bytes without RD (DEPTH 8) -> COUNT = 8, OVERFLOW = 1, first 8 bytes intact; CLR_ERR -> OVERFLOW = 0.
- FIFO full, RD coincident with 9th push -> COUNT stays 8, OVERFLOW = 0, newest byte at tail.
- CS rises after 5 bits, then full byte 0x55 -> only 0x055 stored; with LCD_SPI_RX_FRAMEERR_EN, FRAME_ERR = 1.
- RESET_N low mid-byte and with 3 entries queued -> all outputs 0 immediately; next full byte 0x81 received correctly.
